// File: rtl/sal_bank_ctrl.sv
// Per-bank DRAM command sequencer: holds one request, tracks the open row and
// the intra-bank timing windows, and raises ACT/RD/WR/PRE towards the scheduler.
module sal_bank_ctrl #(
  parameter int unsigned     BA_W  = 3,
  parameter int unsigned     RA_W  = 16,
  parameter int unsigned     CA_W  = 10,
  parameter int unsigned     ID_W  = 4,
  parameter int unsigned     LEN_W = 4,
  parameter int unsigned     TW    = 8,
  parameter logic [BA_W-1:0] BK_ID = {BA_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TW-1:0]    t_rcd_m1_i,
  input  logic [TW-1:0]    t_rp_m1_i,
  input  logic [TW-1:0]    t_ras_m1_i,
  input  logic [TW-1:0]    t_rtp_m1_i,
  input  logic [TW-1:0]    t_wtp_m1_i,
  input  logic [7:0]       row_open_cnt_i,
  input  logic             req_valid_i,
  input  logic             req_wr_i,
  input  logic [ID_W-1:0]  req_id_i,
  input  logic [RA_W-1:0]  req_ra_i,
  input  logic [CA_W-1:0]  req_ca_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             req_ready_o,
  output logic             sched_act_req_o,
  output logic             sched_rd_req_o,
  output logic             sched_wr_req_o,
  output logic             sched_pre_req_o,
  output logic             sched_ref_req_o,
  output logic [BA_W-1:0]  sched_ba_o,
  output logic [RA_W-1:0]  sched_ra_o,
  output logic [CA_W-1:0]  sched_ca_o,
  output logic [ID_W-1:0]  sched_id_o,
  output logic [LEN_W-1:0] sched_len_o,
  input  logic             sched_act_gnt_i,
  input  logic             sched_rd_gnt_i,
  input  logic             sched_wr_gnt_i,
  input  logic             sched_pre_gnt_i
);

  typedef enum logic [1:0] {
    ST_CLOSED      = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_ACTIVE      = 2'd2,
    ST_PRECHARGING = 2'd3
  } state_e;

  localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == T_ZERO) ? v : v - TW'(1);
  endfunction

  state_e           state_q, state_d, st_eff_s;
  logic             pending_q, pending_d;
  logic             pre_commit_q, pre_commit_d;
  logic [RA_W-1:0]  open_row_q, open_row_d;
  logic [TW-1:0]    rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d, rtp_q, rtp_d, wtp_q, wtp_d;
  logic [7:0]       idle_q, idle_d;
  logic             wr_q;
  logic [ID_W-1:0]  id_q;
  logic [RA_W-1:0]  ra_q;
  logic [CA_W-1:0]  ca_q;
  logic [LEN_W-1:0] len_q;

  logic accept_s, row_hit_s, timers_ok_s, idle_exp_s;
  logic act_req_s, rd_req_s, wr_req_s, pre_req_s;
  logic act_gnt_s, rd_gnt_s, wr_gnt_s, pre_gnt_s;

  assign accept_s    = req_valid_i & ~pending_q;
  assign row_hit_s   = (ra_q == open_row_q);
  assign timers_ok_s = (ras_q == T_ZERO) & (rtp_q == T_ZERO) & (wtp_q == T_ZERO);
  assign idle_exp_s  = (row_open_cnt_i != 8'hFF) & (idle_q == row_open_cnt_i);

  // Resolve the effective state: an expired tRCD/tRP window acts as the next state this cycle.
  always_comb begin
    st_eff_s = state_q;
    if (state_q == ST_ACTIVATING && rcd_q == T_ZERO) begin
      st_eff_s = ST_ACTIVE;
    end else if (state_q == ST_PRECHARGING && rp_q == T_ZERO) begin
      st_eff_s = ST_CLOSED;
    end else begin
      st_eff_s = state_q;
    end
  end

  // Command requests from registered state only; a raised precharge holds until granted.
  always_comb begin
    act_req_s = 1'b0;
    rd_req_s  = 1'b0;
    wr_req_s  = 1'b0;
    pre_req_s = 1'b0;
    case (st_eff_s)
      ST_CLOSED: act_req_s = pending_q;
      ST_ACTIVE: begin
        if (pre_commit_q) begin
          pre_req_s = 1'b1;
        end else if (pending_q && row_hit_s) begin
          rd_req_s = ~wr_q;
          wr_req_s = wr_q;
        end else if (pending_q) begin
          pre_req_s = timers_ok_s;
        end else begin
          pre_req_s = timers_ok_s & idle_exp_s;
        end
      end
      default: begin
        act_req_s = 1'b0;
      end
    endcase
  end

  assign act_gnt_s = sched_act_gnt_i & act_req_s;
  assign rd_gnt_s  = sched_rd_gnt_i  & rd_req_s;
  assign wr_gnt_s  = sched_wr_gnt_i  & wr_req_s;
  assign pre_gnt_s = sched_pre_gnt_i & pre_req_s;

  // Next-state, open row, pending flag and precharge commitment.
  always_comb begin
    state_d      = st_eff_s;
    open_row_d   = open_row_q;
    pre_commit_d = pre_req_s & ~pre_gnt_s;
    case (st_eff_s)
      ST_CLOSED: begin
        if (act_gnt_s) begin
          state_d    = ST_ACTIVATING;
          open_row_d = ra_q;
        end else begin
          state_d = ST_CLOSED;
        end
      end
      ST_ACTIVE: begin
        if (pre_gnt_s) begin
          state_d = ST_PRECHARGING;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = st_eff_s;
      end
    endcase
    if (accept_s) begin
      pending_d = 1'b1;
    end else if (rd_gnt_s || wr_gnt_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Timing windows reload on their grant and count down to zero.
  always_comb begin
    rcd_d = act_gnt_s ? t_rcd_m1_i : dec_sat(rcd_q);
    ras_d = act_gnt_s ? t_ras_m1_i : dec_sat(ras_q);
    rtp_d = rd_gnt_s  ? t_rtp_m1_i : dec_sat(rtp_q);
    wtp_d = wr_gnt_s  ? t_wtp_m1_i : dec_sat(wtp_q);
    rp_d  = pre_gnt_s ? t_rp_m1_i  : dec_sat(rp_q);
    if (act_gnt_s || rd_gnt_s || wr_gnt_s) begin
      idle_d = 8'd0;
    end else if (st_eff_s == ST_ACTIVE && !pending_q) begin
      idle_d = (idle_q >= row_open_cnt_i) ? row_open_cnt_i : idle_q + 8'd1;
    end else begin
      idle_d = idle_q;
    end
  end

  // Bank state and timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLOSED;
      pending_q    <= 1'b0;
      pre_commit_q <= 1'b0;
      open_row_q   <= {RA_W{1'b0}};
      rcd_q        <= T_ZERO;
      ras_q        <= T_ZERO;
      rp_q         <= T_ZERO;
      rtp_q        <= T_ZERO;
      wtp_q        <= T_ZERO;
      idle_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pre_commit_q <= pre_commit_d;
      open_row_q   <= open_row_d;
      rcd_q        <= rcd_d;
      ras_q        <= ras_d;
      rp_q         <= rp_d;
      rtp_q        <= rtp_d;
      wtp_q        <= wtp_d;
      idle_q       <= idle_d;
    end
  end

  // One-entry request holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      id_q  <= {ID_W{1'b0}};
      ra_q  <= {RA_W{1'b0}};
      ca_q  <= {CA_W{1'b0}};
      len_q <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      wr_q  <= req_wr_i;
      id_q  <= req_id_i;
      ra_q  <= req_ra_i;
      ca_q  <= req_ca_i;
      len_q <= req_len_i;
    end else begin
      wr_q  <= wr_q;
      id_q  <= id_q;
      ra_q  <= ra_q;
      ca_q  <= ca_q;
      len_q <= len_q;
    end
  end

  assign req_ready_o     = ~pending_q;
  assign sched_act_req_o = act_req_s;
  assign sched_rd_req_o  = rd_req_s;
  assign sched_wr_req_o  = wr_req_s;
  assign sched_pre_req_o = pre_req_s;
  assign sched_ref_req_o = 1'b0;
  assign sched_ba_o      = BK_ID;
  assign sched_ra_o      = ra_q;
  assign sched_ca_o      = ca_q;
  assign sched_id_o      = id_q;
  assign sched_len_o     = len_q;

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Bench for sal_bank_ctrl: directed timing scenarios plus randomized traffic,
// all checked against a timestamp-based model of the bank rules.
module tb_sal_bank_ctrl;

  localparam logic [2:0] BK = 3'd5;

  logic        clk, rst_n;
  logic [7:0]  t_rcd, t_rp, t_ras, t_rtp, t_wtp, row_open_cnt;
  logic        req_valid, req_wr, req_ready;
  logic [3:0]  req_id, req_len;
  logic [15:0] req_ra;
  logic [9:0]  req_ca;
  logic        act_req, rd_req, wr_req, pre_req, ref_req;
  logic        act_gnt, rd_gnt, wr_gnt, pre_gnt;
  logic [2:0]  ba;
  logic [15:0] ra;
  logic [9:0]  ca;
  logic [3:0]  id, len;

  sal_bank_ctrl #(.BK_ID(BK)) dut (
    .clk(clk), .rst_n(rst_n),
    .t_rcd_m1_i(t_rcd), .t_rp_m1_i(t_rp), .t_ras_m1_i(t_ras),
    .t_rtp_m1_i(t_rtp), .t_wtp_m1_i(t_wtp), .row_open_cnt_i(row_open_cnt),
    .req_valid_i(req_valid), .req_wr_i(req_wr), .req_id_i(req_id),
    .req_ra_i(req_ra), .req_ca_i(req_ca), .req_len_i(req_len), .req_ready_o(req_ready),
    .sched_act_req_o(act_req), .sched_rd_req_o(rd_req), .sched_wr_req_o(wr_req),
    .sched_pre_req_o(pre_req), .sched_ref_req_o(ref_req),
    .sched_ba_o(ba), .sched_ra_o(ra), .sched_ca_o(ca), .sched_id_o(id), .sched_len_o(len),
    .sched_act_gnt_i(act_gnt), .sched_rd_gnt_i(rd_gnt), .sched_wr_gnt_i(wr_gnt),
    .sched_pre_gnt_i(pre_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0, cyc = 0;
  int p_rcd, p_ras, p_rp, p_rtp, p_wtp, p_cnt;
  int gnt_delay = 0, gnt_pct = -1, age = 0;

  // reference model: request slot, open row, grant timestamps, quiet-cycle count
  logic        m_pend, m_wr, m_open, m_commit;
  logic [3:0]  m_id, m_len;
  logic [15:0] m_ra, m_row;
  logic [9:0]  m_ca;
  int          t_act, t_rd, t_wr, t_pre, m_quiet;

  logic [3:0]  log_req [0:511];
  logic        log_rdy [0:511];
  logic [15:0] log_ra  [0:511];
  logic [15:0] rows    [0:2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_wr = 1'b0; m_open = 1'b0; m_commit = 1'b0;
    m_id = 4'd0; m_len = 4'd0; m_ra = 16'd0; m_row = 16'd0; m_ca = 10'd0;
    t_act = -100000; t_rd = -100000; t_wr = -100000; t_pre = -100000;
    m_quiet = 0;
  endtask

  // Expected {act,rd,wr,pre} for cycle c from the bank rules.
  function automatic logic [3:0] model_req(input int c);
    logic [3:0] r;
    bit all_ok;
    r = 4'b0000;
    all_ok = (c >= t_act + p_ras + 1) && (c >= t_rd + p_rtp + 1) && (c >= t_wr + p_wtp + 1);
    if (!m_open) begin
      if (m_pend && c >= t_pre + p_rp + 1) r = 4'b1000;
    end else if (c >= t_act + p_rcd + 1) begin
      if (m_commit)                    r = 4'b0001;
      else if (m_pend && m_ra == m_row) r = m_wr ? 4'b0010 : 4'b0100;
      else if (m_pend)                 r = all_ok ? 4'b0001 : 4'b0000;
      else if (p_cnt != 255 && m_quiet >= p_cnt && all_ok) r = 4'b0001;
    end
    return r;
  endfunction

  task automatic step(input bit v, input bit w, input logic [15:0] a,
                      input logic [9:0] c, input logic [3:0] i, input logic [3:0] l);
    logic [3:0] exp, g;
    bit grant, quiet_inc, pend_before;
    @(negedge clk);
    exp = model_req(cyc);
    if (cyc < 512) begin
      log_req[cyc] = {act_req, rd_req, wr_req, pre_req};
      log_rdy[cyc] = req_ready;
      log_ra[cyc]  = ra;
    end
    chk("req", {ref_req, act_req, rd_req, wr_req, pre_req}, {1'b0, exp});
    chk("ready", req_ready, !m_pend);
    if (exp != 4'b0000)
      chk("fields", {ba, ra, ca, id, len}, {BK, m_ra, m_ca, m_id, m_len});
    if (exp != 4'b0000) age++; else age = 0;
    if (gnt_pct >= 0) grant = (exp != 4'b0000) && ($urandom_range(99) < gnt_pct);
    else              grant = (exp != 4'b0000) && (age > gnt_delay);
    g = grant ? exp : 4'b0000;
    if (gnt_pct >= 0 && $urandom_range(99) < 10) g = g | (4'($urandom) & ~exp);
    {act_gnt, rd_gnt, wr_gnt, pre_gnt} = g;
    req_valid = v; req_wr = w; req_ra = a; req_ca = c; req_id = i; req_len = l;
    pend_before = m_pend;
    quiet_inc = m_open && (cyc >= t_act + p_rcd + 1) && !m_pend;
    if (grant) begin
      age = 0;
      case (exp)
        4'b1000: begin m_open = 1'b1; m_row = m_ra; t_act = cyc; m_quiet = 0; quiet_inc = 1'b0; end
        4'b0100: begin t_rd = cyc; m_pend = 1'b0; m_quiet = 0; quiet_inc = 1'b0; end
        4'b0010: begin t_wr = cyc; m_pend = 1'b0; m_quiet = 0; quiet_inc = 1'b0; end
        default: begin m_open = 1'b0; t_pre = cyc; m_commit = 1'b0; end
      endcase
    end else if (exp == 4'b0001) begin
      m_commit = 1'b1;
    end
    if (quiet_inc) m_quiet++;
    if (v && !pend_before) begin
      m_pend = 1'b1; m_wr = w; m_ra = a; m_ca = c; m_id = i; m_len = l;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'd0, 10'd0, 4'd0, 4'd0);
  endtask

  task automatic do_reset(input int rcd, input int ras, input int rp,
                          input int rtp, input int wtp, input int cnt);
    {act_gnt, rd_gnt, wr_gnt, pre_gnt} = 4'b0000;
    req_valid = 1'b0; req_wr = 1'b0; req_ra = 16'd0; req_ca = 10'd0; req_id = 4'd0; req_len = 4'd0;
    p_rcd = rcd; p_ras = ras; p_rp = rp; p_rtp = rtp; p_wtp = wtp; p_cnt = cnt;
    t_rcd = 8'(rcd); t_ras = 8'(ras); t_rp = 8'(rp); t_rtp = 8'(rtp); t_wtp = 8'(wtp);
    row_open_cnt = 8'(cnt);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_req", {ref_req, act_req, rd_req, wr_req, pre_req}, 5'b00000);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_fields", {ba, ra, ca, id, len}, {BK, 34'd0});
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc = 0; age = 0;
  endtask

  initial begin
    int npre;
    rst_n = 1'b1;
    rows[0] = 16'h0012; rows[1] = 16'h0034; rows[2] = 16'h0056;

    // closed-bank read followed by a row-hit write and idle auto-close
    do_reset(3, 9, 3, 2, 5, 8); gnt_pct = -1; gnt_delay = 0;
    step(1'b1, 1'b0, 16'h0012, 10'h005, 4'h3, 4'h2);
    idle(5);
    step(1'b1, 1'b1, 16'h0012, 10'h00A, 4'h7, 4'h1);
    idle(15);
    chk("A_act@1", log_req[1], 4'b1000);
    chk("A_quiet@4", log_req[4], 4'b0000);
    chk("A_rd@5", log_req[5], 4'b0100);
    chk("A_ready@6", log_rdy[6], 1'b1);
    chk("A_wr@7", log_req[7], 4'b0010);
    chk("A_quiet@15", log_req[15], 4'b0000);
    chk("A_pre@16", log_req[16], 4'b0001);

    // row miss right after the read grant
    do_reset(3, 9, 3, 2, 5, 8);
    step(1'b1, 1'b0, 16'h0012, 10'h005, 4'h3, 4'h2);
    idle(5);
    step(1'b1, 1'b0, 16'h0034, 10'h020, 4'h9, 4'h3);
    idle(15);
    chk("B_nopre@10", log_req[10], 4'b0000);
    chk("B_pre@11", log_req[11], 4'b0001);
    chk("B_noact@14", log_req[14], 4'b0000);
    chk("B_act@15", log_req[15], 4'b1000);
    chk("B_act_ra@15", log_ra[15], 16'h0034);
    chk("B_rd@19", log_req[19], 4'b0100);

    // every grant held back five cycles
    do_reset(3, 9, 3, 2, 5, 8); gnt_delay = 5;
    step(1'b1, 1'b0, 16'h0012, 10'h0AB, 4'h5, 4'h4);
    idle(34);
    chk("C_act@6", log_req[6], 4'b1000);
    chk("C_gap@9", log_req[9], 4'b0000);
    chk("C_rd@10", log_req[10], 4'b0100);
    chk("C_rd@15", log_req[15], 4'b0100);
    chk("C_gap@23", log_req[23], 4'b0000);
    chk("C_pre@24", log_req[24], 4'b0001);
    chk("C_pre@29", log_req[29], 4'b0001);
    chk("C_gap@30", log_req[30], 4'b0000);

    // open-page mode never auto-closes
    do_reset(3, 9, 3, 2, 5, 255); gnt_delay = 0;
    step(1'b1, 1'b0, 16'h0012, 10'h001, 4'h1, 4'h1);
    idle(310);
    npre = 0;
    for (int k = 0; k < 311; k++) if (log_req[k][0]) npre++;
    chk("D_no_pre", npre, 0);

    // zero idle threshold: close as soon as tRTP allows
    do_reset(3, 9, 3, 2, 5, 0); gnt_delay = 4;
    step(1'b1, 1'b0, 16'h0012, 10'h001, 4'h1, 4'h1);
    idle(20);
    chk("D0_rd@13", log_req[13], 4'b0100);
    chk("D0_gap@15", log_req[15], 4'b0000);
    chk("D0_pre@16", log_req[16], 4'b0001);

    // reset while a read waits for its grant
    do_reset(3, 9, 3, 2, 5, 8); gnt_delay = 2;
    step(1'b1, 1'b0, 16'h0012, 10'h001, 4'h1, 4'h1);
    idle(8);
    chk("E_rd_wait@8", log_req[8], 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("E_async_drop", {ref_req, act_req, rd_req, wr_req, pre_req}, 5'b00000);
    chk("E_ready", req_ready, 1'b1);
    {act_gnt, rd_gnt, wr_gnt, pre_gnt} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(); cyc = 0; age = 0; gnt_delay = 0;
    step(1'b1, 1'b0, 16'h0077, 10'h011, 4'h2, 4'h3);
    idle(6);
    chk("E_fresh_act@1", log_req[1], 4'b1000);
    chk("E_fresh_ra@1", log_ra[1], 16'h0077);
    chk("E_rd@5", log_req[5], 4'b0100);

    // randomized traffic with random timing and grant latency
    for (int r = 0; r < 6; r++) begin
      int cnts [0:5];
      cnts[0] = 0; cnts[1] = 3; cnts[2] = 8; cnts[3] = 255; cnts[4] = 1; cnts[5] = 20;
      do_reset($urandom_range(6), $urandom_range(12), $urandom_range(6),
               $urandom_range(6), $urandom_range(8), cnts[r]);
      gnt_pct = $urandom_range(90, 40);
      for (int k = 0; k < 400; k++)
        step($urandom_range(99) < 35, 1'($urandom), rows[$urandom_range(2)],
             10'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
